// File: rtl/register_file_sb_pkg.sv
// rtl/register_file_sb_pkg.sv - shared defaults and helpers for the register file
package register_file_sb_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_RD_PORTS = 2;

    // Index of the hard-wired zero register
    localparam int REG_ZERO_IDX = 0;

    // Number of 8-bit byte lanes in a register of the given width
    function automatic int byte_lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/register_file_sb_reg_cell.sv
// rtl/register_file_sb_reg_cell.sv - one register with synchronous reset and byte-lane enables
module register_file_sb_reg_cell
    import register_file_sb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          we,
    input  logic [byte_lanes(DATA_W)-1:0] byte_en,
    input  logic [DATA_W-1:0]             din,
    output logic [DATA_W-1:0]             dout
);

    localparam int LANES = byte_lanes(DATA_W);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    // Replace only the enabled byte lanes; disabled lanes keep their value
    always_comb begin
        data_d = data_q;
        if (we) begin
            for (int k = 0; k < LANES; k++) begin
                if (byte_en[k]) begin
                    data_d[k*8 +: 8] = din[k*8 +: 8];
                end
            end
        end
    end

    // Register state, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign dout = data_q;

endmodule

// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - parametrised register file with byte writes, bypass and busy scoreboard
module register_file_sb
    import register_file_sb_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int RD_PORTS = DEF_RD_PORTS,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic [RD_PORTS*ADDR_W-1:0]    Adr,
    output logic [RD_PORTS*DATA_W-1:0]    Dout,
    output logic [RD_PORTS-1:0]           Busy,
    input  logic [ADDR_W-1:0]             Awr,
    input  logic [DATA_W-1:0]             Din,
    input  logic                          WrEn,
    input  logic [byte_lanes(DATA_W)-1:0] ByteEn,
    input  logic [ADDR_W-1:0]             Ares,
    input  logic                          ResEn,
    output logic                          AnyBusy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int LANES = byte_lanes(DATA_W);

    logic [DATA_W-1:0] reg_val [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [DATA_W-1:0] wr_merged;

    // Storage: one cell per register, register 0 tied off when it is the zero register
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        if (ZERO_REG != 0 && i == REG_ZERO_IDX) begin : g_zero
            assign reg_val[i] = '0;
        end else begin : g_cell
            logic cell_we;
            assign cell_we = WrEn && (Awr == ADDR_W'(i));
            register_file_sb_reg_cell #(
                .DATA_W (DATA_W)
            ) u_cell (
                .clk     (Clk),
                .rst     (Rst),
                .we      (cell_we),
                .byte_en (ByteEn),
                .din     (Din),
                .dout    (reg_val[i])
            );
        end
    end

    // Value the write target will hold after this edge, used for forwarding
    always_comb begin
        wr_merged = reg_val[Awr];
        for (int k = 0; k < LANES; k++) begin
            if (ByteEn[k]) begin
                wr_merged[k*8 +: 8] = Din[k*8 +: 8];
            end
        end
    end

    // Scoreboard update: release first so a same-address reserve wins
    always_comb begin
        busy_d = busy_q;
        if (WrEn) begin
            busy_d[Awr] = 1'b0;
        end
        if (ResEn) begin
            busy_d[Ares] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_d[REG_ZERO_IDX] = 1'b0;
        end
    end

    // Scoreboard state; reset discards all pending reservations
    always_ff @(posedge Clk) begin
        if (Rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Read ports: stored value, overridden by forwarding, overridden by the zero register
    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [ADDR_W-1:0] rd_adr;
        logic [DATA_W-1:0] rd_data;
        logic              rd_busy;

        assign rd_adr = Adr[p*ADDR_W +: ADDR_W];

        // Combinational read with optional same-cycle write forwarding
        always_comb begin
            rd_data = reg_val[rd_adr];
            rd_busy = busy_q[rd_adr];
            if (BYPASS != 0 && WrEn && rd_adr == Awr) begin
                rd_data = wr_merged;
                rd_busy = ResEn && (Ares == Awr);
            end
            if (ZERO_REG != 0 && rd_adr == ADDR_W'(REG_ZERO_IDX)) begin
                rd_data = '0;
                rd_busy = 1'b0;
            end
        end

        assign Dout[p*DATA_W +: DATA_W] = rd_data;
        assign Busy[p]                  = rd_busy;
    end

    assign AnyBusy = |busy_q;

endmodule

// File: tb/tb_register_file_sb.sv
// tb/tb_register_file_sb.sv - directed self-checking bench for register_file_sb
module tb_register_file_sb;

    logic        Clk;
    logic        Rst;

    // Shared stimulus for the 32-bit instances (a: bypass+zero reg, b: neither)
    logic [9:0]  adr;
    logic [4:0]  awr;
    logic [31:0] din;
    logic        wren;
    logic [3:0]  be;
    logic [4:0]  ares;
    logic        resen;

    logic [63:0] dout_a, dout_b;
    logic [1:0]  busy_a, busy_b;
    logic        any_a, any_b;

    // 64-bit, 8-register, 4-port instance
    logic [11:0]  adr_c;
    logic [2:0]   awr_c;
    logic [63:0]  din_c;
    logic         wren_c;
    logic [7:0]   be_c;
    logic [2:0]   ares_c;
    logic         resen_c;
    logic [255:0] dout_c;
    logic [3:0]   busy_c;
    logic         any_c;

    int n_cmp;
    int n_err;

    register_file_sb #(
        .DATA_W(32), .ADDR_W(5), .RD_PORTS(2), .BYPASS(1), .ZERO_REG(1)
    ) u_a (
        .Clk(Clk), .Rst(Rst), .Adr(adr), .Dout(dout_a), .Busy(busy_a),
        .Awr(awr), .Din(din), .WrEn(wren), .ByteEn(be),
        .Ares(ares), .ResEn(resen), .AnyBusy(any_a)
    );

    register_file_sb #(
        .DATA_W(32), .ADDR_W(5), .RD_PORTS(2), .BYPASS(0), .ZERO_REG(0)
    ) u_b (
        .Clk(Clk), .Rst(Rst), .Adr(adr), .Dout(dout_b), .Busy(busy_b),
        .Awr(awr), .Din(din), .WrEn(wren), .ByteEn(be),
        .Ares(ares), .ResEn(resen), .AnyBusy(any_b)
    );

    register_file_sb #(
        .DATA_W(64), .ADDR_W(3), .RD_PORTS(4), .BYPASS(1), .ZERO_REG(1)
    ) u_c (
        .Clk(Clk), .Rst(Rst), .Adr(adr_c), .Dout(dout_c), .Busy(busy_c),
        .Awr(awr_c), .Din(din_c), .WrEn(wren_c), .ByteEn(be_c),
        .Ares(ares_c), .ResEn(resen_c), .AnyBusy(any_c)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        wren    = 1'b0;
        be      = 4'h0;
        resen   = 1'b0;
        wren_c  = 1'b0;
        be_c    = 8'h00;
        resen_c = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
        wren = 1'b1;
        awr  = a;
        din  = d;
        be   = m;
    endtask

    task automatic res(input logic [4:0] a);
        resen = 1'b1;
        ares  = a;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        Rst   = 1'b1;
        adr   = '0;
        awr   = '0;
        din   = '0;
        ares  = '0;
        adr_c = '0;
        awr_c = '0;
        din_c = '0;
        ares_c = '0;
        idle();
        tick();
        tick();
        Rst = 1'b0;
        #1;

        // Reset state
        adr = {5'd5, 5'd3};
        #1;
        chk("rst_dout_a", dout_a, 64'h0);
        chk("rst_busy_a", {62'h0, busy_a}, 64'h0);
        chk("rst_any_a", {63'h0, any_a}, 64'h0);
        chk("rst_dout_c", dout_c[63:0], 64'h0);

        // Write r5, reserve r6, then reset discards both
        wr(5'd5, 32'hDEADBEEF, 4'hF);
        res(5'd6);
        tick();
        idle();
        adr = {5'd6, 5'd5};
        #1;
        chk("pre_rst_r5", {32'h0, dout_a[31:0]}, 64'hDEADBEEF);
        chk("pre_rst_busy6", {63'h0, busy_a[1]}, 64'h1);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        #1;
        chk("post_rst_r5", {32'h0, dout_a[31:0]}, 64'h0);
        chk("post_rst_busy6", {63'h0, busy_a[1]}, 64'h0);
        chk("post_rst_any", {63'h0, any_a}, 64'h0);
        chk("post_rst_r5_b", {32'h0, dout_b[31:0]}, 64'h0);

        // Byte-lane write
        wr(5'd3, 32'h11223344, 4'hF);
        tick();
        wr(5'd3, 32'hAABBCCDD, 4'b0101);
        tick();
        idle();
        adr = {5'd0, 5'd3};
        #1;
        chk("byte_wr_a", {32'h0, dout_a[31:0]}, 64'h11BB33DD);
        chk("byte_wr_b", {32'h0, dout_b[31:0]}, 64'h11BB33DD);

        // r7: write and reserve at the same edge -> reserve wins
        wr(5'd7, 32'h12345678, 4'hF);
        res(5'd7);
        tick();
        idle();
        adr = {5'd7, 5'd7};
        #1;
        chk("rsv_wins_busy", {62'h0, busy_a}, 64'h3);
        chk("rsv_wins_data", dout_a, 64'h12345678_12345678);

        // Full-width bypass on both ports, releases r7
        wr(5'd7, 32'h0000CAFE, 4'hF);
        #1;
        chk("byp_dout_a", dout_a, 64'h0000CAFE_0000CAFE);
        chk("byp_busy_a", {62'h0, busy_a}, 64'h0);
        chk("nobyp_dout_b", dout_b, 64'h12345678_12345678);
        chk("nobyp_busy_b", {62'h0, busy_b}, 64'h3);
        tick();
        idle();
        #1;
        chk("after_byp_b", dout_b, 64'h0000CAFE_0000CAFE);
        chk("after_byp_busy_b", {62'h0, busy_b}, 64'h0);

        // Partial bypass with reserve on the same register keeps busy
        wr(5'd7, 32'hFFFFFFEF, 4'b0001);
        res(5'd7);
        #1;
        chk("byp_merge_a", {32'h0, dout_a[31:0]}, 64'h0000CAEF);
        chk("byp_rsv_busy_a", {62'h0, busy_a}, 64'h3);
        tick();
        idle();
        #1;
        chk("rsv_after_byp", {62'h0, busy_a}, 64'h3);

        // Release with ByteEn=0: data untouched, busy cleared
        wr(5'd7, 32'hFFFFFFFF, 4'h0);
        tick();
        idle();
        #1;
        chk("be0_data", dout_a, 64'h0000CAEF_0000CAEF);
        chk("be0_busy", {62'h0, busy_a}, 64'h0);

        // Scoreboard on r9
        adr = {5'd10, 5'd9};
        res(5'd9);
        #1;
        chk("sb_not_yet", {63'h0, busy_a[0]}, 64'h0);
        tick();
        idle();
        #1;
        chk("sb_set", {63'h0, busy_a[0]}, 64'h1);
        chk("sb_any", {63'h0, any_a}, 64'h1);
        wr(5'd9, 32'h1, 4'hF);
        res(5'd9);
        tick();
        idle();
        #1;
        chk("sb_same_addr", {63'h0, busy_a[0]}, 64'h1);
        wr(5'd9, 32'h2, 4'hF);
        res(5'd10);
        tick();
        idle();
        #1;
        chk("sb_diff_addr", {62'h0, busy_a}, 64'h2);
        wr(5'd10, 32'h0, 4'h0);
        tick();
        idle();
        #1;
        chk("sb_clear", {62'h0, busy_a}, 64'h0);
        chk("sb_any_clear", {63'h0, any_a}, 64'h0);
        chk("sb_r9_data", {32'h0, dout_a[31:0]}, 64'h2);

        // Zero register
        adr = {5'd0, 5'd0};
        wr(5'd0, 32'hFFFFFFFF, 4'hF);
        res(5'd0);
        #1;
        chk("zero_byp_a", dout_a, 64'h0);
        chk("zero_byp_busy_a", {62'h0, busy_a}, 64'h0);
        tick();
        idle();
        #1;
        chk("zero_a", dout_a, 64'h0);
        chk("zero_busy_a", {62'h0, busy_a}, 64'h0);
        chk("zero_any_a", {63'h0, any_a}, 64'h0);
        chk("r0_plain_b", dout_b, 64'hFFFFFFFF_FFFFFFFF);
        chk("r0_busy_b", {62'h0, busy_b}, 64'h3);
        chk("r0_any_b", {63'h0, any_b}, 64'h1);

        // Wide instance: upper-lane write forwarded to ports 2 and 3
        adr_c  = {3'd5, 3'd5, 3'd1, 3'd0};
        wren_c = 1'b1;
        awr_c  = 3'd5;
        din_c  = 64'h0123456789ABCDEF;
        be_c   = 8'hF0;
        #1;
        chk("c_byp_p3", dout_c[255:192], 64'h01234567_00000000);
        chk("c_byp_p2", dout_c[191:128], 64'h01234567_00000000);
        chk("c_p1_r1", dout_c[127:64], 64'h0);
        tick();
        idle();
        adr_c = {3'd5, 3'd5, 3'd5, 3'd5};
        resen_c = 1'b1;
        ares_c  = 3'd5;
        tick();
        idle();
        #1;
        chk("c_p0", dout_c[63:0], 64'h01234567_00000000);
        chk("c_p1", dout_c[127:64], 64'h01234567_00000000);
        chk("c_p3", dout_c[255:192], 64'h01234567_00000000);
        chk("c_busy", {60'h0, busy_c}, 64'hF);
        chk("c_any", {63'h0, any_c}, 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
